misr_ora: RTL and testbench
===========================

MISR_ORA -- requirements
Module: misr_ora

Interface
REQ-001 Parameter BITS, default 4: response width; SHALL be at least 2.
REQ-002 Parameter POLY, default 4'b0011: feedback tap mask, BITS wide; bit i set means sig[i] feeds back.
REQ-003 Parameter SEED, default 0: initial signature value, BITS wide.
REQ-004 Parameter NUM_PATTERNS, default 15: number of responses to compact per run; SHALL be at least 1.
REQ-005 Parameter GOLDEN, default 0: expected final signature, BITS wide.
REQ-006 clk  input  1  clock; all logic rising-edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 start  input  1  single-cycle run request.
REQ-009 resp_valid  input  1  resp carries a response from the circuit under test this cycle.
REQ-010 resp  input  BITS  circuit-under-test response word, driven from patterns produced by the upstream LFSR generator.
REQ-011 busy  output  1  high in COMPACT and COMPARE.
REQ-012 done  output  1  high in DONE.
REQ-013 pass  output  1  final signature equals GOLDEN; valid only while done=1.
REQ-014 signature  output  BITS  current MISR contents.
REQ-015 pat_count  output  clog2(NUM_PATTERNS+1)  number of responses accepted in the current run.

Function
REQ-016 FSM states: IDLE, COMPACT, COMPARE, DONE; all outputs registered.
REQ-017 IDLE with start=1: next cycle COMPACT, signature<=SEED, pat_count<=0, pass<=0.
REQ-018 MISR update on an accepted response: fb = XOR-reduce(POLY & signature); sig[BITS-1] <= resp[BITS-1]^fb; sig[i] <= sig[i+1]^resp[i] for i<BITS-1.
REQ-019 COMPACT with resp_valid=1: apply REQ-018, pat_count increments by 1; resp_valid=0: signature and pat_count hold.
REQ-020 When the accepted response brings pat_count to NUM_PATTERNS, the FSM SHALL move to COMPARE on the same edge; responses arriving after that are ignored.
REQ-021 COMPARE lasts exactly one cycle: pass <= (signature==GOLDEN); next state DONE.
REQ-022 DONE: done=1, pass and signature hold until start or rst.
REQ-023 start in DONE behaves as in IDLE (REQ-017): a new run begins, done clears the next cycle.
REQ-024 start while busy=1 SHALL be ignored; the run is neither restarted nor aborted.
REQ-025 Latency: with resp_valid held high, done rises NUM_PATTERNS+2 cycles after the start cycle.
REQ-026 resp is ignored outside COMPACT regardless of resp_valid.

Reset
REQ-027 rst=1 at a clock edge: state<=IDLE, signature<=SEED, pat_count<=0, busy=0, done=0, pass=0; rst has priority over start and resp_valid.
REQ-028 rst mid-run abandons the run; no partial signature is retained.

Configuration
REQ-029 Macro MISR_ORA_XMASK_EN defined: adds input resp_mask (BITS wide, 1 = bit unknown/X). Masked response bits are forced to 0 before the REQ-018 update.
REQ-030 MISR_ORA_XMASK_EN undefined: resp_mask port absent; resp is used unmasked; behaviour otherwise identical.

Verification (BITS=4, POLY=4'b0011, SEED=0 unless stated)
REQ-031 NUM_PATTERNS=2, GOLDEN=4'b1101; start, then resp 4'b1010 and 4'b0000 with resp_valid=1 on consecutive cycles -> signature 1010 then 1101; done=1 with pass=1 four cycles after start.
REQ-032 Same run with GOLDEN=4'b1100 -> done=1, pass=0, signature=1101.
REQ-033 NUM_PATTERNS=2; resp_valid low for 3 cycles between the two responses -> signature and pat_count hold during the gap; final result as in REQ-031, done delayed by 3 cycles.
REQ-034 start pulsed during COMPACT; then rst asserted after one accepted response -> no restart on start; after rst: IDLE, signature=0000, pat_count=0, done=0, pass=0.
REQ-035 MISR_ORA_XMASK_EN: responses 4'b1111 with resp_mask 4'b0101, then 4'b0000 with mask 0 -> signature after first response = 1010; final = 1101, identical to REQ-031.
REQ-036 Back-to-back runs: start in DONE -> done clears next cycle; second identical run gives the same signature and pass.

Source files
------------

// File: rtl/misr_ora.sv
// misr_ora: multiple-input signature register output response analyser.
// Compacts NUM_PATTERNS response words from a circuit under test into a
// BITS-wide signature, then compares it with GOLDEN.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous, active-high reset
//   start      - single-cycle run request (ignored while busy)
//   resp_valid - resp carries a response this cycle
//   resp       - response word from the circuit under test
//   resp_mask  - (only with MISR_ORA_XMASK_EN) 1 = bit unknown, forced to 0
//   busy       - high while compacting or comparing
//   done       - high once the run has finished
//   pass       - final signature equals GOLDEN (valid while done=1)
//   signature  - current MISR contents
//   pat_count  - responses accepted in the current run
//
// Optional feature macro: MISR_ORA_XMASK_EN (adds resp_mask input).
module misr_ora #(
  parameter int unsigned     BITS         = 4,
  parameter logic [BITS-1:0] POLY         = 4'b0011,
  parameter logic [BITS-1:0] SEED         = '0,
  parameter int unsigned     NUM_PATTERNS = 15,
  parameter logic [BITS-1:0] GOLDEN       = '0,
  localparam int unsigned    CW           = $clog2(NUM_PATTERNS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            resp_valid,
  input  logic [BITS-1:0] resp,
`ifdef MISR_ORA_XMASK_EN
  input  logic [BITS-1:0] resp_mask,
`endif
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [BITS-1:0] signature,
  output logic [CW-1:0]   pat_count
);

  typedef enum logic [1:0] {IDLE, COMPACT, COMPARE, DONE} state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PATTERNS - 1);

  state_t            state_q, state_n;
  logic [BITS-1:0]   sig_n;
  logic [CW-1:0]     cnt_n;
  logic              pass_n;
  logic [BITS-1:0]   resp_eff;
  logic [BITS-1:0]   misr_next;
  logic              fb;

`ifdef MISR_ORA_XMASK_EN
  assign resp_eff = resp & ~resp_mask;
`else
  assign resp_eff = resp;
`endif

  // Shift toward bit 0; feedback from tapped bits enters at the MSB.
  always_comb begin
    misr_next = '0;
    fb = ^(POLY & signature);
    misr_next[BITS-1] = resp_eff[BITS-1] ^ fb;
    for (int unsigned i = 0; i < BITS - 1; i++) begin
      misr_next[i] = signature[i+1] ^ resp_eff[i];
    end
  end

  always_comb begin
    state_n = state_q;
    sig_n   = signature;
    cnt_n   = pat_count;
    pass_n  = pass;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_n = COMPACT;
          sig_n   = SEED;
          cnt_n   = '0;
          pass_n  = 1'b0;
        end
      end
      COMPACT: begin
        if (resp_valid) begin
          sig_n = misr_next;
          cnt_n = pat_count + CW'(1);
          if (pat_count == LAST_IDX) begin
            state_n = COMPARE;
          end
        end
      end
      COMPARE: begin
        pass_n  = (signature == GOLDEN);
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      signature <= SEED;
      pat_count <= '0;
      pass      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      signature <= sig_n;
      pat_count <= cnt_n;
      pass      <= pass_n;
      busy      <= (state_n == COMPACT) || (state_n == COMPARE);
      done      <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_misr_ora.sv
// Directed self-checking bench for misr_ora (BITS=4, POLY=0011, SEED=0,
// NUM_PATTERNS=2). Instance a uses GOLDEN=1101, instance b GOLDEN=1100.
module tb_misr_ora;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       resp_valid;
  logic [3:0] resp;
`ifdef MISR_ORA_XMASK_EN
  logic [3:0] resp_mask;
`endif
  logic       busy_a, done_a, pass_a;
  logic [3:0] sig_a;
  logic [1:0] cnt_a;
  logic       busy_b, done_b, pass_b;
  logic [3:0] sig_b;
  logic [1:0] cnt_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  misr_ora #(.BITS(4), .POLY(4'b0011), .SEED(4'b0000), .NUM_PATTERNS(2), .GOLDEN(4'b1101)) dut_a (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
`ifdef MISR_ORA_XMASK_EN
    .resp_mask(resp_mask),
`endif
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .pat_count(cnt_a)
  );

  misr_ora #(.BITS(4), .POLY(4'b0011), .SEED(4'b0000), .NUM_PATTERNS(2), .GOLDEN(4'b1100)) dut_b (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
`ifdef MISR_ORA_XMASK_EN
    .resp_mask(resp_mask),
`endif
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .pat_count(cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; resp_valid = 1'b1; resp = 4'b1111;
    tick();
    tick();
    rst = 1'b0; start = 1'b0; resp_valid = 1'b0;
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done_a); end
    tests++; if (pass_a !== 1'b0) begin fails++; $display("FAIL reset_pass got %b exp 0", pass_a); end
    tests++; if (sig_a !== 4'b0000) begin fails++; $display("FAIL reset_sig got %b exp 0000", sig_a); end
    tests++; if (cnt_a !== 2'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", cnt_a); end
  endtask

  task automatic test_basic_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (busy_a !== 1'b1 || cnt_a !== 2'd0) begin fails++; $display("FAIL basic_start got busy=%b cnt=%0d exp busy=1 cnt=0", busy_a, cnt_a); end
    resp_valid = 1'b1; resp = 4'b1010;
    tick();
    tests++; if (sig_a !== 4'b1010 || cnt_a !== 2'd1) begin fails++; $display("FAIL basic_resp1 got sig=%b cnt=%0d exp sig=1010 cnt=1", sig_a, cnt_a); end
    resp = 4'b0000;
    tick();
    tests++; if (sig_a !== 4'b1101 || cnt_a !== 2'd2) begin fails++; $display("FAIL basic_resp2 got sig=%b cnt=%0d exp sig=1101 cnt=2", sig_a, cnt_a); end
    tests++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin fails++; $display("FAIL basic_compare got busy=%b done=%b exp busy=1 done=0", busy_a, done_a); end
    // extra response during COMPARE must be ignored
    resp = 4'b0111;
    tick();
    resp_valid = 1'b0;
    tests++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin fails++; $display("FAIL basic_done got done=%b busy=%b exp done=1 busy=0", done_a, busy_a); end
    tests++; if (pass_a !== 1'b1) begin fails++; $display("FAIL basic_pass_a got %b exp 1", pass_a); end
    tests++; if (done_b !== 1'b1 || pass_b !== 1'b0) begin fails++; $display("FAIL basic_pass_b got done=%b pass=%b exp done=1 pass=0", done_b, pass_b); end
    tests++; if (sig_a !== 4'b1101 || sig_b !== 4'b1101) begin fails++; $display("FAIL basic_final_sig got a=%b b=%b exp 1101", sig_a, sig_b); end
    resp_valid = 1'b1; resp = 4'b1001;
    tick(); tick();
    resp_valid = 1'b0;
    tests++; if (done_a !== 1'b1 || pass_a !== 1'b1 || sig_a !== 4'b1101 || cnt_a !== 2'd2) begin fails++; $display("FAIL basic_done_hold got done=%b pass=%b sig=%b cnt=%0d exp 1 1 1101 2", done_a, pass_a, sig_a, cnt_a); end
  endtask

  task automatic test_gap();
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (done_a !== 1'b0 || sig_a !== 4'b0000) begin fails++; $display("FAIL gap_restart got done=%b sig=%b exp done=0 sig=0000", done_a, sig_a); end
    resp_valid = 1'b1; resp = 4'b1010;
    tick();
    resp_valid = 1'b0; resp = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (sig_a !== 4'b1010 || cnt_a !== 2'd1 || done_a !== 1'b0 || busy_a !== 1'b1) begin fails++; $display("FAIL gap_hold%0d got sig=%b cnt=%0d done=%b busy=%b exp 1010 1 0 1", k, sig_a, cnt_a, done_a, busy_a); end
    end
    resp_valid = 1'b1; resp = 4'b0000;
    tick();
    resp_valid = 1'b0;
    tests++; if (sig_a !== 4'b1101 || cnt_a !== 2'd2) begin fails++; $display("FAIL gap_resp2 got sig=%b cnt=%0d exp 1101 2", sig_a, cnt_a); end
    tick();
    tests++; if (done_a !== 1'b1 || pass_a !== 1'b1) begin fails++; $display("FAIL gap_done got done=%b pass=%b exp 1 1", done_a, pass_a); end
  endtask

  task automatic test_start_ignored_and_rst();
    start = 1'b1;
    tick();
    start = 1'b0;
    resp_valid = 1'b1; resp = 4'b1010;
    tick();
    resp_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (sig_a !== 4'b1010 || cnt_a !== 2'd1 || busy_a !== 1'b1) begin fails++; $display("FAIL busy_start got sig=%b cnt=%0d busy=%b exp 1010 1 1", sig_a, cnt_a, busy_a); end
    rst = 1'b1; start = 1'b1; resp_valid = 1'b1; resp = 4'b0110;
    tick();
    rst = 1'b0; start = 1'b0; resp_valid = 1'b0;
    tests++; if (sig_a !== 4'b0000 || cnt_a !== 2'd0 || busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0) begin fails++; $display("FAIL midrun_rst got sig=%b cnt=%0d busy=%b done=%b pass=%b exp 0000 0 0 0 0", sig_a, cnt_a, busy_a, done_a, pass_a); end
    resp_valid = 1'b1; resp = 4'b1111;
    tick();
    resp_valid = 1'b0;
    tests++; if (sig_a !== 4'b0000 || cnt_a !== 2'd0 || busy_a !== 1'b0) begin fails++; $display("FAIL idle_ignores_resp got sig=%b cnt=%0d busy=%b exp 0000 0 0", sig_a, cnt_a, busy_a); end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      tests++; if (done_a !== 1'b0 || busy_a !== 1'b1 || pass_a !== 1'b0 || sig_a !== 4'b0000 || cnt_a !== 2'd0) begin fails++; $display("FAIL b2b_start%0d got done=%b busy=%b pass=%b sig=%b cnt=%0d exp 0 1 0 0000 0", r, done_a, busy_a, pass_a, sig_a, cnt_a); end
      resp_valid = 1'b1; resp = 4'b1010;
      tick();
      resp = 4'b0000;
      tick();
      resp_valid = 1'b0;
      tick();
      tests++; if (done_a !== 1'b1 || pass_a !== 1'b1 || sig_a !== 4'b1101) begin fails++; $display("FAIL b2b_result%0d got done=%b pass=%b sig=%b exp 1 1 1101", r, done_a, pass_a, sig_a); end
    end
  endtask

`ifdef MISR_ORA_XMASK_EN
  task automatic test_xmask();
    start = 1'b1;
    tick();
    start = 1'b0;
    resp_valid = 1'b1; resp = 4'b1111; resp_mask = 4'b0101;
    tick();
    tests++; if (sig_a !== 4'b1010) begin fails++; $display("FAIL xmask_resp1 got %b exp 1010", sig_a); end
    resp = 4'b0000; resp_mask = 4'b0000;
    tick();
    resp_valid = 1'b0;
    tick();
    tests++; if (sig_a !== 4'b1101 || done_a !== 1'b1 || pass_a !== 1'b1) begin fails++; $display("FAIL xmask_final got sig=%b done=%b pass=%b exp 1101 1 1", sig_a, done_a, pass_a); end
  endtask
`endif

  initial begin
    rst = 1'b0; start = 1'b0; resp_valid = 1'b0; resp = 4'b0000;
`ifdef MISR_ORA_XMASK_EN
    resp_mask = 4'b0000;
`endif
    @(negedge clk);
    test_reset();
    test_basic_run();
    test_gap();
    test_start_ignored_and_rst();
    test_back_to_back();
`ifdef MISR_ORA_XMASK_EN
    test_xmask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
